// File: rtl/pipo_arb_pkg.sv
// Shared types and default sizing for the pipo_arb round-robin parallel-load arbiter.
package pipo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_HOLD_CYC = 2;
    localparam int HOLD_CNT_W   = 4;

endpackage

// File: rtl/pipo_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/pipo_arb.sv
// Round-robin arbiter sharing one parallel-in/parallel-out register among N_REQ requesters.
// Optional same-winner relock when PIPO_ARB_LOCK_EN is defined.
import pipo_arb_pkg::*;

module pipo_arb #(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
`ifdef PIPO_ARB_LOCK_EN
    input  logic [N_REQ-1:0]       lock,
`endif
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   ld,
    output logic [WIDTH-1:0]       q,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [HOLD_CNT_W-1:0] HOLD_INIT =
        (HOLD_CYC > 0) ? HOLD_CNT_W'(HOLD_CYC - 1) : '0;

    state_e                 state_q, state_d;
    logic [N_REQ-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic [HOLD_CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_REQ-1:0]       pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic [N_REQ-1:0]       win_oh;
    logic [WIDTH-1:0]       win_data;
    logic                   relock;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    always_comb begin
        win_oh        = '0;
        win_oh[win_q] = 1'b1;
    end

    assign win_data = din[int'(win_q)*WIDTH +: WIDTH];

`ifdef PIPO_ARB_LOCK_EN
    assign relock = lock[win_q] & req[win_q];
`else
    assign relock = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    gnt_d   = pick_oh;
                    win_d   = pick_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                q_d   = win_data;
                ptr_d = win_q;
                gnt_d = '0;
                if (HOLD_CYC == 0) begin
                    // No hold window: the exit decision is taken right here.
                    state_d = relock ? LOAD : IDLE;
                    gnt_d   = relock ? win_oh : '0;
                end else begin
                    state_d = HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = relock ? LOAD : IDLE;
                    gnt_d   = relock ? win_oh : '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            win_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign ld   = (state_q == LOAD);
    assign ack  = (state_q == LOAD) ? gnt_q : '0;
    assign busy = (state_q != IDLE);
    assign q    = q_q;

endmodule

// File: tb/tb_pipo_arb.sv
// Directed bench for pipo_arb: vector table plus hand sequences for rotation, reset and hold=0.
module tb_pipo_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'h0;
    logic [15:0] din = 16'h0000;
`ifdef PIPO_ARB_LOCK_EN
    logic [3:0]  lock = 4'h0;
`endif

    logic [3:0] gnt, ack, q;
    logic       ld, busy;
    logic [3:0] gnt0, ack0, q0;
    logic       ld0, busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipo_arb #(.N_REQ(4), .WIDTH(4), .HOLD_CYC(2)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
`ifdef PIPO_ARB_LOCK_EN
        .lock (lock),
`endif
        .gnt  (gnt),
        .ack  (ack),
        .ld   (ld),
        .q    (q),
        .busy (busy)
    );

    pipo_arb #(.N_REQ(4), .WIDTH(4), .HOLD_CYC(0)) u_dut0 (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
`ifdef PIPO_ARB_LOCK_EN
        .lock (lock),
`endif
        .gnt  (gnt0),
        .ack  (ack0),
        .ld   (ld0),
        .q    (q0),
        .busy (busy0)
    );

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] din;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        ld;
        logic        busy;
        logic [3:0]  q;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ld(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (ld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bit          ok;
        logic [15:0] d;
        logic [3:0]  exp_oh;
        logic [3:0]  exp_q;

        //             rst   req   din       gnt   ack   ld    busy  q
        tbl[0]  = '{1'b1, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 4'h4, 16'h0B00, 4'h4, 4'h4, 1'b1, 1'b1, 4'h0};
        tbl[2]  = '{1'b0, 4'h0, 16'h0A00, 4'h0, 4'h0, 1'b0, 1'b1, 4'hA};
        tbl[3]  = '{1'b0, 4'h2, 16'h0A00, 4'h0, 4'h0, 1'b0, 1'b1, 4'hA};
        tbl[4]  = '{1'b0, 4'h0, 16'h0A00, 4'h0, 4'h0, 1'b0, 1'b0, 4'hA};
        tbl[5]  = '{1'b0, 4'h0, 16'h0A00, 4'h0, 4'h0, 1'b0, 1'b0, 4'hA};
        tbl[6]  = '{1'b0, 4'hF, 16'h4321, 4'h8, 4'h8, 1'b1, 1'b1, 4'hA};
        tbl[7]  = '{1'b0, 4'hF, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b1, 4'h4};
        tbl[8]  = '{1'b0, 4'hF, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b1, 4'h4};
        tbl[9]  = '{1'b0, 4'hF, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4};
        tbl[10] = '{1'b0, 4'hF, 16'h4321, 4'h1, 4'h1, 1'b1, 1'b1, 4'h4};
        tbl[11] = '{1'b0, 4'hF, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b1, 4'h1};

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            din = tbl[i].din;
            tick();
            chk($sformatf("vec%0d_gnt", i),  32'(gnt),  32'(tbl[i].gnt));
            chk($sformatf("vec%0d_ack", i),  32'(ack),  32'(tbl[i].ack));
            chk($sformatf("vec%0d_ld", i),   32'(ld),   32'(tbl[i].ld));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_q", i),    32'(q),    32'(tbl[i].q));
        end

        // Rotation with all requesters active, fresh data presented during each LOAD.
        do_reset();
        req = 4'hF;
        for (int k = 0; k < 12; k++) begin
            wait_ld(8, ok);
            chk($sformatf("rot%0d_found", k), 32'(ok), 32'd1);
            exp_oh = 4'b0001 << (k % 4);
            chk($sformatf("rot%0d_gnt", k), 32'(gnt), 32'(exp_oh));
            chk($sformatf("rot%0d_ack", k), 32'(ack), 32'(exp_oh));
            d     = 16'($urandom);
            din   = d;
            exp_q = 4'(d >> ((k % 4) * 4));
            tick();
            chk($sformatf("rot%0d_q", k), 32'(q), 32'(exp_q));
        end

        // Reset asserted in the middle of LOAD.
        req = 4'h0;
        wait_idle(8, ok);
        chk("mr_idle1", 32'(ok), 32'd1);
        req = 4'b0100;
        din = 16'h0700;
        wait_ld(8, ok);
        chk("mr_ld1", 32'(ok), 32'd1);
        tick();
        chk("mr_q7", 32'(q), 32'h7);
        req = 4'h0;
        wait_idle(8, ok);
        chk("mr_idle2", 32'(ok), 32'd1);
        req = 4'b0100;
        din = 16'h0300;
        wait_ld(8, ok);
        chk("mr_ld2", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mr_gnt", 32'(gnt), 32'h0);
        chk("mr_ack", 32'(ack), 32'h0);
        chk("mr_ld", 32'(ld), 32'h0);
        chk("mr_q", 32'(q), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        req = 4'hF;
        tick();
        chk("mr_held_ack", 32'(ack), 32'h0);
        chk("mr_held_q", 32'(q), 32'h0);
        rst = 1'b0;
        tick();
        chk("mr_resume_gnt", 32'(gnt), 32'h1);
        chk("mr_resume_ld", 32'(ld), 32'h1);

        // HOLD_CYC=0 instance: single requester reloads every other cycle.
        req = 4'h0;
        do_reset();
        req = 4'b0001;
        din = 16'h0005;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("h0_%0d_ld", k),   32'(ld0),   (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("h0_%0d_busy", k), 32'(busy0), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("h0_%0d_gnt", k),  32'(gnt0),  (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k >= 1) begin
                chk($sformatf("h0_%0d_q", k), 32'(q0), 32'h5);
            end
        end

`ifdef PIPO_ARB_LOCK_EN
        // Locked winner keeps the register across consecutive loads.
        req = 4'h0;
        do_reset();
        lock = 4'b1000;
        req  = 4'b1000;
        wait_ld(8, ok);
        chk("lk_first", 32'(gnt), 32'h8);
        req = 4'b1001;
        for (int r = 0; r < 3; r++) begin
            wait_ld(8, ok);
            chk($sformatf("lk%0d_found", r), 32'(ok), 32'd1);
            chk($sformatf("lk%0d_gnt", r), 32'(gnt), 32'h8);
        end
        lock = 4'h0;
        wait_ld(8, ok);
        chk("lk_release_gnt", 32'(gnt), 32'h1);
        req = 4'h0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipo_arb.md
PIPO_ARB -- requirements
Module: pipo_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 4: register data width.
REQ-003 SHALL have parameter HOLD_CYC, default 2: idle cycles after each load (0..15).
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-006 SHALL have port req  input  N_REQ: per-requester load request, level.
REQ-007 SHALL have port din  input  N_REQ*WIDTH: packed data; requester i uses bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port gnt  output  N_REQ: one-hot grant, registered.
REQ-009 SHALL have port ack  output  N_REQ: one-cycle load-done pulse to the granted requester.
REQ-010 SHALL have port ld  output  1: high for exactly the cycle in which q is loaded.
REQ-011 SHALL have port q  output  WIDTH: shared parallel-out register.
REQ-012 SHALL have port busy  output  1: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the states IDLE, LOAD and HOLD.
REQ-014 IDLE with any req bit high SHALL, at the next edge, pick a winner round-robin (first set bit after ptr, wrapping), set gnt one-hot and enter LOAD.
REQ-015 IDLE with req all-zero SHALL remain in IDLE with gnt = 0.
REQ-016 LOAD SHALL last exactly one cycle: ld=1, ack[winner]=1, gnt held; at the closing edge q <= din slice of winner and ptr <= winner.
REQ-017 After LOAD, state SHALL enter HOLD for HOLD_CYC cycles with gnt=0 and ld=0; HOLD_CYC=0 SHALL go directly LOAD->IDLE.
REQ-018 HOLD SHALL return to IDLE after its final cycle; arbitration SHALL happen only in IDLE.
REQ-019 Latency: req sampled at edge t SHALL give gnt and ld high in cycle t..t+1 and updated q after edge t+1.
REQ-020 Deassertion of req during LOAD SHALL NOT abort the load; din SHALL be sampled at the closing LOAD edge.
REQ-021 A req that drops before being granted SHALL be ignored without any ack.
REQ-022 q SHALL hold its value whenever ld=0.
REQ-023 With all N_REQ requesting continuously, grants SHALL rotate 0,1,...,N_REQ-1,0 with no requester starved.

Reset
REQ-024 rst high SHALL immediately force state IDLE, gnt=0, ack=0, ld=0, busy=0, q=0 and ptr=N_REQ-1, so requester 0 has priority first.
REQ-025 Reset asserted mid-LOAD SHALL leave q=0, issue no ack, and resume arbitration from IDLE on the first edge after release.

Configuration
REQ-026 With PIPO_ARB_LOCK_EN defined, the module SHALL have an extra input lock[N_REQ]; at HOLD exit (or LOAD exit when HOLD_CYC=0), if lock[winner] and req[winner] are both high, it SHALL re-enter LOAD for the same winner without round-robin.
REQ-027 Without PIPO_ARB_LOCK_EN, the lock port SHALL be absent and every load SHALL pass through IDLE arbitration.

Structure
REQ-028 A package pipo_arb_pkg SHALL hold the state enum (IDLE, LOAD, HOLD) and the default constants for N_REQ, WIDTH and HOLD_CYC.
REQ-029 The round-robin pick SHALL be a combinational sub-module rr_pick(req, ptr -> onehot, idx), instantiated once.

Verification
REQ-030 Single request: after reset, req=4'b0100 with din slice 2 = 4'hA -> gnt=4'b0100 and ld=1 one cycle later, ack[2] pulses once, q=4'hA after the next edge, and busy stays high for 1+2 cycles.
REQ-031 Rotation: req=4'b1111 held for 12 loads -> ack order 0,1,2,3,0,1,2,3,..., and each q equals the matching slice of din.
REQ-032 Mid-operation reset: rst asserted during LOAD -> gnt, ack, ld and q all 0 immediately, no ack is observed, and arbitration resumes at requester 0.
REQ-033 Early drop: req[1] pulses for 1 cycle while the arbiter is in HOLD -> no gnt[1] and no ack[1] is ever issued.
REQ-034 Boundary: HOLD_CYC=0 with req=4'b0001 held -> loads repeat every 2 cycles and busy toggles 1,0.
REQ-035 With PIPO_ARB_LOCK_EN: lock[3]=1 and req=4'b1001 held -> requester 3 receives consecutive grants while requester 0 receives none until lock[3] drops.
